// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: CPU and IO requester ports plus the single-port data memory.
// slave = arbiter view, master = requester/memory environment view.
interface dmem_arbiter_if #(
  parameter int Dbits = 32,
  parameter int Abits = 32
);
  logic             cpu_req;
  logic             cpu_wr;
  logic [Abits-1:0] cpu_addr;
  logic [Dbits-1:0] cpu_wdata;
  logic             cpu_ack;
  logic [Dbits-1:0] cpu_rdata;
  logic             cpu_stall;

  logic             io_req;
  logic             io_wr;
  logic [Abits-1:0] io_addr;
  logic [Dbits-1:0] io_wdata;
  logic             io_ack;
  logic [Dbits-1:0] io_rdata;

  logic             mem_en;
  logic             mem_wr;
  logic [Abits-1:0] mem_addr;
  logic [Dbits-1:0] mem_wdata;
  logic [Dbits-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    input  io_req, io_wr, io_addr, io_wdata,
    output io_ack, io_rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    output io_req, io_wr, io_addr, io_wdata,
    input  io_ack, io_rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU, IO) arbiter for a single-port data memory: IDLE -> ISSUE -> RESP, fixed 2-cycle latency.
// Optional macro DMEM_ARB_RR_EN: round-robin tie-break; default build gives ties to the CPU.
module dmem_arbiter #(
  parameter int Dbits = 32,
  parameter int Abits = 32
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef enum logic {GNT_CPU, GNT_IO} gnt_t;

  state_t           state, state_nxt;
  gnt_t             last_gnt;
  logic             cpu_win;
  logic             take;
  logic [Abits-1:0] lat_addr;
  logic [Dbits-1:0] lat_wdata;
  logic             lat_wr;

  logic             mem_en, mem_wr;
  logic [Abits-1:0] mem_addr;
  logic [Dbits-1:0] mem_wdata;
  logic             cpu_ack, io_ack;
  logic [Dbits-1:0] cpu_rdata, io_rdata;

`ifdef DMEM_ARB_RR_EN
  // On a tie the CPU wins only if IO held the previous grant.
  assign cpu_win = bus.cpu_req & (~bus.io_req | (last_gnt == GNT_IO));
`else
  assign cpu_win = bus.cpu_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last_gnt  <= GNT_IO;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wr    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        last_gnt  <= cpu_win ? GNT_CPU : GNT_IO;
        lat_addr  <= cpu_win ? bus.cpu_addr  : bus.io_addr;
        lat_wdata <= cpu_win ? bus.cpu_wdata : bus.io_wdata;
        lat_wr    <= cpu_win ? bus.cpu_wr    : bus.io_wr;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_ack   = 1'b0;
    io_ack    = 1'b0;
    cpu_rdata = '0;
    io_rdata  = '0;
    unique case (state)
      IDLE: begin
        if (bus.cpu_req | bus.io_req) begin
          take      = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mem_en    = 1'b1;
        mem_wr    = lat_wr;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        state_nxt = RESP;
      end
      RESP: begin
        // last_gnt still names the owner of the access now completing.
        if (last_gnt == GNT_CPU) begin
          cpu_ack   = 1'b1;
          cpu_rdata = bus.mem_rdata;
        end else begin
          io_ack    = 1'b1;
          io_rdata  = bus.mem_rdata;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.mem_en    = mem_en;
  assign bus.mem_wr    = mem_wr;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.cpu_ack   = cpu_ack;
  assign bus.cpu_rdata = cpu_rdata;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_ack;
  assign bus.io_ack    = io_ack;
  assign bus.io_rdata  = io_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: timestamp-based access model, behavioural memory, directed vectors.
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
  localparam logic [63:0] TIE_ORDER = 64'd5;  // C,I,C,I as 0101
`else
  localparam bit RR = 1'b0;
  localparam logic [63:0] TIE_ORDER = 64'd0;  // C,C,C,C
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.Dbits(DW), .Abits(AW)) bus ();
  dmem_arbiter #(.Dbits(DW), .Abits(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an access granted from the inputs of cycle g issues in g+1 and
  // acknowledges in g+2; the arbiter may grant again from cycle g+3 on.
  int          cyc = 0;
  int          g = -100;
  bit          m_io_owner = 1'b0;
  bit          m_last_io = 1'b1;
  bit          io_wins;
  logic [31:0] m_addr, m_wdata;
  logic        m_wr;

  always @(posedge clk) begin
    if (reset) begin
      g = -100;
      m_last_io = 1'b1;
    end else if (cyc >= g + 3 && (bus.cpu_req || bus.io_req)) begin
      if (bus.cpu_req && bus.io_req) io_wins = RR && !m_last_io;
      else io_wins = bus.io_req;
      m_io_owner = io_wins;
      m_last_io  = io_wins;
      m_addr     = io_wins ? bus.io_addr  : bus.cpu_addr;
      m_wdata    = io_wins ? bus.io_wdata : bus.cpu_wdata;
      m_wr       = io_wins ? bus.io_wr    : bus.cpu_wr;
      g = cyc;
    end
    cyc = cyc + 1;
  end

  // Behavioural single-port memory; junk on mem_rdata when no read is returning.
  logic [31:0] tbmem [logic [31:0]];
  logic        s_en = 1'b0, s_wr = 1'b0;
  logic [31:0] s_addr = '0, s_wdata = '0;

  always @(posedge clk) begin
    if (s_en && s_wr) tbmem[s_addr] = s_wdata;
    if (s_en && !s_wr) bus.mem_rdata <= tbmem.exists(s_addr) ? tbmem[s_addr] : ~s_addr;
    else bus.mem_rdata <= $urandom;
  end

  bit exp_en, exp_ack, ec, ei;
  always @(negedge clk) begin
    if (cyc >= 1) begin
      exp_en  = (cyc == g + 1);
      exp_ack = (cyc == g + 2);
      ec = exp_ack && !m_io_owner;
      ei = exp_ack && m_io_owner;
      check("mem_en", bus.mem_en, exp_en);
      check("mem_wr", bus.mem_wr, exp_en && m_wr);
      if (exp_en) begin
        check("mem_addr", bus.mem_addr, m_addr);
        check("mem_wdata", bus.mem_wdata, m_wdata);
      end
      check("cpu_ack", bus.cpu_ack, ec);
      check("io_ack", bus.io_ack, ei);
      check("cpu_rdata", bus.cpu_rdata, ec ? bus.mem_rdata : 32'd0);
      check("io_rdata", bus.io_rdata, ei ? bus.mem_rdata : 32'd0);
      check("cpu_stall", bus.cpu_stall, bus.cpu_req && !ec);
    end
    s_en = bus.mem_en;
    s_wr = bus.mem_wr;
    s_addr = bus.mem_addr;
    s_wdata = bus.mem_wdata;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int          n_acks;
  logic [63:0] order;

  initial begin
    bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.io_req  = 0; bus.io_wr  = 0; bus.io_addr  = '0; bus.io_wdata  = '0;
    tbmem[32'h40] = 32'hDEADBEEF;

    // Reset state
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_acks", {bus.cpu_ack, bus.io_ack}, 0);
    check("rst_rdata", {bus.cpu_rdata, bus.io_rdata}, 0);
    step(10);

    // CPU read of 0x40
    bus.cpu_req = 1; bus.cpu_wr = 0; bus.cpu_addr = 32'h40;
    @(negedge clk); check("rd_stall_n", bus.cpu_stall, 1);
    step(1);
    @(negedge clk);
    check("rd_en_n1", bus.mem_en, 1);
    check("rd_addr_n1", bus.mem_addr, 32'h40);
    check("rd_stall_n1", bus.cpu_stall, 1);
    step(1);
    @(negedge clk);
    check("rd_ack_n2", bus.cpu_ack, 1);
    check("rd_data_n2", bus.cpu_rdata, 32'hDEADBEEF);
    check("rd_stall_n2", bus.cpu_stall, 0);
    step(1);
    bus.cpu_req = 0;
    step(2);

    // IO write 0x10 <- 0x12345678
    bus.io_req = 1; bus.io_wr = 1; bus.io_addr = 32'h10; bus.io_wdata = 32'h12345678;
    step(1);
    @(negedge clk);
    check("wr_en_n1", {bus.mem_en, bus.mem_wr}, 2'b11);
    check("wr_addr_n1", bus.mem_addr, 32'h10);
    check("wr_data_n1", bus.mem_wdata, 32'h12345678);
    step(1);
    @(negedge clk);
    check("wr_ioack_n2", bus.io_ack, 1);
    check("wr_cpuack_n2", bus.cpu_ack, 0);
    step(1);
    bus.io_req = 0; bus.io_wr = 0;
    step(1);

    // CPU reads back what IO wrote
    bus.cpu_req = 1; bus.cpu_addr = 32'h10;
    step(2);
    @(negedge clk);
    check("rb_data", bus.cpu_rdata, 32'h12345678);
    step(1);
    bus.cpu_req = 0;
    step(1);

    // Both requesting for 12 cycles, starting from reset
    reset = 1'b1; step(1); reset = 1'b0;
    bus.cpu_req = 1; bus.cpu_addr = 32'h100;
    bus.io_req = 1;  bus.io_addr = 32'h200;
    n_acks = 0; order = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.cpu_ack || bus.io_ack) begin
        n_acks++;
        order = {order[62:0], bus.io_ack};
      end
      step(1);
    end
    bus.cpu_req = 0; bus.io_req = 0;
    check("tie_acks", n_acks, 4);
    check("tie_order", order, TIE_ORDER);
    step(2);

    // Reset pulsed in the ISSUE cycle of a CPU read
    bus.cpu_req = 1; bus.cpu_addr = 32'h40;
    step(1);
    reset = 1'b1;
    @(negedge clk); check("ri_en_issue", bus.mem_en, 1);
    step(1);
    reset = 1'b0;
    @(negedge clk);
    check("ri_no_ack", bus.cpu_ack, 0);
    check("ri_no_en", bus.mem_en, 0);
    step(1);
    @(negedge clk); check("ri_reissue", bus.mem_en, 1);
    step(1);
    @(negedge clk);
    check("ri_ack", bus.cpu_ack, 1);
    check("ri_data", bus.cpu_rdata, 32'hDEADBEEF);
    step(1);
    bus.cpu_req = 0;
    step(1);

    // IO drops its request during ISSUE
    bus.io_req = 1; bus.io_wr = 0; bus.io_addr = 32'h40;
    step(1);
    bus.io_req = 0; bus.io_addr = 32'h99;
    @(negedge clk); check("drop_addr", bus.mem_addr, 32'h40);
    step(1);
    @(negedge clk);
    check("drop_ack", bus.io_ack, 1);
    check("drop_data", bus.io_rdata, 32'hDEADBEEF);
    step(2);

    // Mixed traffic, model-checked every cycle
    for (int i = 0; i < 60; i++) begin
      bus.cpu_req = 1'($urandom_range(0, 1)); bus.cpu_wr = 1'($urandom_range(0, 1));
      bus.cpu_addr = 32'($urandom_range(0, 7)) << 2; bus.cpu_wdata = $urandom;
      bus.io_req = 1'($urandom_range(0, 1)); bus.io_wr = 1'($urandom_range(0, 1));
      bus.io_addr = 32'($urandom_range(0, 7)) << 2; bus.io_wdata = $urandom;
      step(1);
    end
    bus.cpu_req = 0; bus.io_req = 0; bus.cpu_wr = 0; bus.io_wr = 0;
    step(4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter Dbits, default 32: data word width for all data ports.
REQ-002 SHALL have parameter Abits, default 32: address width for all address ports.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports cpu_req/cpu_wr  input  1 each  CPU access request and write qualifier.
REQ-006 SHALL have ports cpu_addr  input  Abits and cpu_wdata  input  Dbits: CPU command.
REQ-007 SHALL have ports cpu_ack  output  1, cpu_rdata  output  Dbits, cpu_stall  output  1 (processor enable = ~cpu_stall).
REQ-008 SHALL have ports io_req/io_wr  input  1, io_addr  input  Abits, io_wdata  input  Dbits: second requester (loader/DMA).
REQ-009 SHALL have ports io_ack  output  1, io_rdata  output  Dbits.
REQ-010 SHALL have ports mem_en/mem_wr  output  1, mem_addr  output  Abits, mem_wdata  output  Dbits, mem_rdata  input  Dbits: single-port data memory, read data valid one cycle after mem_en.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, ISSUE, RESP.
REQ-012 IDLE: no request -> stay IDLE; any request -> select owner, latch owner's addr/wr/wdata into registers, go to ISSUE.
REQ-013 ISSUE: mem_en=1, mem_wr=latched wr, mem_addr/mem_wdata=latched values; always go to RESP next cycle.
REQ-014 RESP: owner's ack=1 for exactly this cycle; owner's rdata=mem_rdata; always go to IDLE next cycle.
REQ-015 Latency SHALL be fixed: request seen in IDLE at cycle N -> mem_en at N+1 -> ack at N+2; maximum throughput one access per 3 cycles.
REQ-016 Requester SHALL hold req and command stable until ack; a requester may keep req high after ack to request another access, arbitrated in the following IDLE.
REQ-017 A request dropped during ISSUE or RESP SHALL NOT abort the access: access completes from latched command and ack still pulses.
REQ-018 Outside RESP, or for the non-owner, ack=0 and rdata=0.
REQ-019 mem_en and mem_wr SHALL be 0 in every state except ISSUE; writes occur only in ISSUE.
REQ-020 cpu_stall SHALL equal cpu_req AND NOT cpu_ack (combinational); zero when CPU not requesting.
REQ-021 Simultaneous cpu_req and io_req in IDLE SHALL be resolved per REQ-030/031; a single requester is always granted.
REQ-022 A register last_gnt SHALL record the owner of each grant (updated on IDLE->ISSUE).

Reset
REQ-023 While reset is high at a clock edge: state<=IDLE, last_gnt<=IO, latched addr/wdata<=0, latched wr<=0.
REQ-024 After reset: mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0, cpu_ack=io_ack=0, cpu_rdata=io_rdata=0.
REQ-025 Reset asserted during ISSUE or RESP SHALL abandon the access: no ack issued, no write after the reset edge.
REQ-026 Reset SHALL take priority over every FSM transition.

Configuration
REQ-030 With macro DMEM_ARB_RR_EN defined: tie in IDLE granted to the requester not equal to last_gnt (round-robin; CPU wins first tie after reset).
REQ-031 Without DMEM_ARB_RR_EN: tie always granted to CPU (fixed priority); last_gnt still maintained but unused for arbitration.

Verification
REQ-040 Reset then idle 10 cycles -> mem_en=0, both acks 0, cpu_stall=0 throughout.
REQ-041 CPU read addr 0x40, mem returns 0xDEADBEEF -> mem_en/addr 0x40 at N+1, cpu_ack=1 and cpu_rdata=0xDEADBEEF at N+2, cpu_stall high N..N+1 only.
REQ-042 IO write addr 0x10 data 0x12345678 -> mem_en=mem_wr=1, mem_addr=0x10, mem_wdata=0x12345678 at N+1, io_ack at N+2, cpu signals untouched.
REQ-043 Both request continuously for 12 cycles with DMEM_ARB_RR_EN -> acks alternate CPU, IO, CPU, IO; without macro -> four CPU acks, zero IO acks.
REQ-044 CPU request, reset pulsed in ISSUE cycle -> no cpu_ack, mem_en=0 next cycle, FSM IDLE; request re-served 3 cycles after reset release.
REQ-045 IO drops io_req in ISSUE cycle -> io_ack still pulses at N+2 with access to latched address.
